// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out one byte, check ACK.
// Optional feature macro: PS2_HOST_TX_TIMEOUT_EN builds the request and packet timeouts (status 10).
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_TIMEOUT    = 750000,
  parameter int PKT_TIMEOUT    = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic [2:0] dbg_state,
  output logic [1:0] dbg_lines
);

  // Handshake: a byte is taken on any rising clock edge where tx_valid & tx_ready are both high;
  // tx_valid while tx_ready is low is ignored and nothing is queued.

  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_TIMEOUT) ? INHIBIT_CYCLES : REQ_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > PKT_TIMEOUT) ? MAX_A : PKT_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_TIMEOUT - 1);
  // Packet window counts cycles elapsed after the first detected fall.
  localparam logic [CW-1:0] PKT_LAST = CW'(PKT_TIMEOUT);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_WAITHI  = 3'd5
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [2:0]    dat_sync;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [3:0]    bit_idx;
  logic [3:0]    idx_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          fall;
  logic          timeout;

  assign fall      = clk_sync[2] & ~clk_sync[1];
  assign idx_next  = bit_idx + 4'd1;
  assign cnt_next  = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
  assign dbg_state = state;
  assign dbg_lines = {clk_sync[2], dat_sync[2]};

  always_comb begin
    timeout = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    case (state)
      S_REQ:                    timeout = (cnt == REQ_LAST);
      S_SEND, S_ACK, S_WAITHI:  timeout = (cnt == PKT_LAST);
      default:                  timeout = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      clk_sync   <= 3'b111;
      dat_sync   <= 3'b111;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
      bit_idx    <= 4'd0;
      cnt        <= '0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= 2'b00;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk_in};
      dat_sync <= {dat_sync[1:0], ps2_dat_in};
      done     <= 1'b0;
      cnt      <= cnt_next;
      if (timeout) begin
        // Timeout outranks a fall seen in the same cycle.
        state      <= S_IDLE;
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        status     <= 2'b10;
        done       <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
              data_q     <= tx_data;
              parity_q   <= ~^tx_data;
              cnt        <= '0;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt == INH_LAST) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              cnt        <= '0;
              state      <= S_REQ;
            end
          end
          S_REQ: begin
            if (fall) begin
              ps2_dat_oe <= ~data_q[0];
              bit_idx    <= 4'd0;
              cnt        <= '0;
              state      <= S_SEND;
            end
          end
          S_SEND: begin
            if (fall) begin
              bit_idx <= idx_next;
              if (idx_next <= 4'd7) begin
                ps2_dat_oe <= ~data_q[idx_next[2:0]];
              end else if (idx_next == 4'd8) begin
                ps2_dat_oe <= ~parity_q;
              end else begin
                ps2_dat_oe <= 1'b0;
                state      <= S_ACK;
              end
            end
          end
          S_ACK: begin
            if (fall) begin
              status <= dat_sync[1] ? 2'b01 : 2'b00;
              cnt    <= '0;
              state  <= S_WAITHI;
            end
          end
          S_WAITHI: begin
            if (clk_sync[1]) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
